alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that sits directly in front of the team's 1-bit ALU slice and turns it into a WIDTH-bit ALU. It latches two WIDTH-bit operands and an opcode, then presents one bit pair per clock, LSB first, to the slice. It feeds the slice's carry-out back as the next carry-in and shifts the slice's result bit into a result register. It reports completion with a one-cycle `done` pulse.

---
 rtl/alu_serial_ctrl_pkg.sv | 27 ++
 rtl/alu_serial_ctrl_if.sv | 24 ++
 rtl/alu_serial_ctrl_dp.sv | 78 +++++++
 rtl/alu_serial_ctrl.sv | 106 ++++++++++
 tb/tb_alu_serial_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared types for the bit-serial ALU sequencer: FSM state encoding, opcode
// names and the bit-counter width helper.
package alu_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The sequencer never decodes these; they are shared with the slice and its users.
  typedef enum logic [1:0] {
    OP_00 = 2'b00,
    OP_01 = 2'b01,
    OP_10 = 2'b10,
    OP_11 = 2'b11
  } op_e;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between a user and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output start, op, a, b, cin0,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, op, a, b, cin0,
    output busy, done, result, cout
  );
endinterface

// File: rtl/alu_serial_ctrl_dp.sv
// Datapath of the serial sequencer: operand shift registers, carry and opcode
// registers, bit counter and the result shift register.
module alu_serial_ctrl_dp
  import alu_serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_cin0,
  input  logic             i_slice_out,
  input  logic             i_slice_carry,
  output logic             o_sa0,
  output logic             o_sb0,
  output logic             o_cr,
  output logic [1:0]       o_opr,
  output logic             o_last,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  op_e              r_opr;
  logic             r_cr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_opr    <= OP_00;
      r_cr     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (i_load) begin
      r_sa     <= i_a;
      r_sb     <= i_b;
      r_opr    <= op_e'(i_op);
      r_cr     <= i_cin0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (i_step) begin
      r_sa     <= r_sa >> 1;
      r_sb     <= r_sb >> 1;
      r_result <= {i_slice_out, r_result[WIDTH-1:1]};
      r_cr     <= i_slice_carry;
      // Counter parks on WIDTH-1 for the last bit so it never wraps mid-operation.
      if (w_last) begin
        r_cout <= i_slice_carry;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sa0    = r_sa[0];
  assign o_sb0    = r_sb[0];
  assign o_cr     = r_cr;
  assign o_opr    = r_opr;
  assign o_last   = w_last;
  assign o_result = r_result;
  assign o_cout   = r_cout;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that drives a 1-bit ALU slice LSB first to build a
// WIDTH-bit operation, with a one-cycle done pulse on completion.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  alu_serial_ctrl_if.slave   bus,
  output logic               slice_a,
  output logic               slice_b,
  output logic               slice_c,
  output logic               slice_s0,
  output logic               slice_s1,
  input  logic               slice_out,
  input  logic               slice_carry
);

  state_e           r_state;
  state_e           w_next;
  logic             r_busy;
  logic             r_done;
  logic             w_run;
  logic             w_load;
  logic             w_sa0;
  logic             w_sb0;
  logic             w_cr;
  logic [1:0]       w_opr;
  logic             w_last;
  logic [WIDTH-1:0] w_result;
  logic             w_cout;

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_RUN);
      r_done  <= (w_next == ST_DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run    = (r_state == ST_RUN);
    w_load   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    slice_a  = 1'b0;
    slice_b  = 1'b0;
    slice_c  = 1'b0;
    slice_s0 = 1'b0;
    slice_s1 = 1'b0;
    if (w_run) begin
      slice_a  = w_sa0;
      slice_b  = w_sb0;
      slice_c  = w_cr;
      slice_s0 = w_opr[0];
      slice_s1 = w_opr[1];
    end
  end

  alu_serial_ctrl_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_step       (w_run),
    .i_a          (bus.a),
    .i_b          (bus.b),
    .i_op         (bus.op),
    .i_cin0       (bus.cin0),
    .i_slice_out  (slice_out),
    .i_slice_carry(slice_carry),
    .o_sa0        (w_sa0),
    .o_sb0        (w_sb0),
    .o_cr         (w_cr),
    .o_opr        (w_opr),
    .o_last       (w_last),
    .o_result     (w_result),
    .o_cout       (w_cout)
  );

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = w_result;
  assign bus.cout   = w_cout;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (reset)
    !(r_busy && r_done));
  a_done_single: assert property (@(posedge clk) disable iff (reset)
    r_done |=> !r_done);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Randomized self-checking bench: the slice is a full adder, so every operation
// must produce {cout,result} = a + b + cin0.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slice_a, slice_b, slice_c, slice_s0, slice_s1;
  logic slice_out, slice_carry;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_done = 0;

  alu_serial_ctrl_if #(.WIDTH(W)) bus();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_c    (slice_c),
    .slice_s0   (slice_s0),
    .slice_s1   (slice_s1),
    .slice_out  (slice_out),
    .slice_carry(slice_carry)
  );

  assign slice_out   = slice_a ^ slice_b ^ slice_c;
  assign slice_carry = (slice_a & slice_b) | (slice_a & slice_c) | (slice_b & slice_c);

  always #250 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [1:0] op, input logic st);
    bus.a = a; bus.b = b; bus.cin0 = c; bus.op = op; bus.start = st;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_slice"}, 64'({slice_a, slice_b, slice_c, slice_s0, slice_s1}), 64'd0);
  endtask

  // Called at a negedge with start=1 and the operands already driven.
  task automatic run_op(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec,
                        input logic [1:0] eop, input bit keep, input bit gap,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc,
                        input logic [1:0] nop);
    logic [W:0] sum;
    longint unsigned m, cv;
    int k;
    sum = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    @(posedge clk);
    @(negedge clk);
    k = 0;
    while (bus.done !== 1'b1 && k < int'(W) + 4) begin
      if (k < int'(W)) begin
        m  = (64'd1 << k) - 64'd1;
        cv = (((64'(ea) & m) + (64'(eb) & m) + 64'(ec)) >> k) & 64'd1;
        chk("run_busy", 64'(bus.busy), 64'd1);
        chk("slice_a", 64'(slice_a), 64'(ea[k]));
        chk("slice_b", 64'(slice_b), 64'(eb[k]));
        chk("slice_c", 64'(slice_c), cv);
        chk("slice_op", 64'({slice_s1, slice_s0}), 64'(eop));
      end
      drive(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("done_latency", 64'(k), 64'(W));
    chk("result", 64'(bus.result), 64'(sum[W-1:0]));
    chk("cout", 64'(bus.cout), 64'(sum[W]));
    chk("done_busy", 64'(bus.busy), 64'd0);
    chk("done_slice", 64'({slice_a, slice_b, slice_c, slice_s0, slice_s1}), 64'd0);
    if (gap) chk("done_gap", 64'(cyc - last_done), 64'(W + 1));
    last_done = cyc;
    if (keep) begin
      drive(na, nb, nc, nop, 1'b1);
    end else begin
      drive(na, nb, nc, nop, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk_quiet("after_done");
    end
  endtask

  logic [W-1:0] ta [3];
  logic [W-1:0] tb [3];
  logic         tc [3];
  logic [1:0]   to [3];
  logic [W-1:0] ra, rb;
  logic         rc;
  logic [1:0]   ro;
  int           nd;

  initial begin
    drive('0, '0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk_quiet("idle");
      chk("idle_result", 64'(bus.result), 64'd0);
      chk("idle_cout", 64'(bus.cout), 64'd0);
    end

    drive(8'h5A, 8'h3C, 1'b0, 2'b00, 1'b1);
    run_op(8'h5A, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);
    drive(8'hFF, 8'h01, 1'b0, 2'b00, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);
    drive(8'hFF, 8'h00, 1'b1, 2'b00, 1'b1);
    run_op(8'hFF, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);

    for (int i = 0; i < 3; i++) begin
      ta[i] = W'($urandom); tb[i] = W'($urandom); tc[i] = 1'($urandom); to[i] = 2'($urandom);
    end
    drive(ta[0], tb[0], tc[0], to[0], 1'b1);
    run_op(ta[0], tb[0], tc[0], to[0], 1'b1, 1'b0, ta[1], tb[1], tc[1], to[1]);
    run_op(ta[1], tb[1], tc[1], to[1], 1'b1, 1'b1, ta[2], tb[2], tc[2], to[2]);
    run_op(ta[2], tb[2], tc[2], to[2], 1'b0, 1'b1, '0, '0, 1'b0, 2'b00);

    ra = W'($urandom); rb = W'($urandom);
    drive(ra, rb, 1'b0, 2'b10, 1'b1);
    run_op(ra, rb, 1'b0, 2'b10, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);

    drive(8'hFF, 8'h00, 1'b0, 2'b01, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_result", 64'(bus.result), 64'hF0);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #10 reset = 1'b1;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_result", 64'(bus.result), 64'd0);
    chk("async_rst_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    drive(8'h5A, 8'h3C, 1'b1, 2'b11, 1'b1);
    run_op(8'h5A, 8'h3C, 1'b1, 2'b11, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); ro = 2'($urandom);
      drive(ra, rb, rc, ro, 1'b1);
      run_op(ra, rb, rc, ro, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
